// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared definitions for the 4-bit ALU and its issue stage:
//               op encodings, flag bit positions inside the packed flag
//               vector, and the issue-stage state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU operation encodings (3-bit select)
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_NOT = 3'd2;  // not a
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LT  = 3'd6;
    localparam logic [2:0] OP_EQ  = 3'd7;

    // Bit positions inside the packed flag vector {equal, smaller, overflow, zero, c}
    localparam int FLG_C    = 0;
    localparam int FLG_ZERO = 1;
    localparam int FLG_OVF  = 2;
    localparam int FLG_LT   = 3;
    localparam int FLG_EQ   = 4;
    localparam int FLAGS_W  = 5;

    // Issue-stage states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Sequential front-end for the combinational 4-bit ALU.
//               Accepts one command per valid/ready handshake, registers the
//               operands onto the ALU inputs, captures result and flags one
//               cycle later and holds them until the consumer takes them.
//               Keeps an accumulator (last result) for chained operations and
//               a wrapping count of completed operations.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   in_valid/in_ready        command handshake
//   in_sel, in_a, in_b       op select and operands
//   in_use_acc               take operand a from the accumulator
//   alu_sel, alu_a, alu_b    registered ALU inputs
//   alu_result, alu_c, alu_zero, alu_overflow, alu_smaller, alu_equal
//                            ALU outputs
//   out_valid/out_ready      result handshake
//   out_result, out_flags    captured result and {equal,smaller,overflow,zero,c}
//   acc                      accumulator
//   op_count                 completed operations (wraps)
//
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    // command side
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_sel,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_use_acc,
    // ALU side
    output logic [2:0]         alu_sel,
    output logic [WIDTH-1:0]   alu_a,
    output logic [WIDTH-1:0]   alu_b,
    input  logic [WIDTH-1:0]   alu_result,
    input  logic               alu_c,
    input  logic               alu_zero,
    input  logic               alu_overflow,
    input  logic               alu_smaller,
    input  logic               alu_equal,
    // result side
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic [FLAGS_W-1:0] out_flags,
    output logic [WIDTH-1:0]   acc,
    output logic [CNT_W-1:0]   op_count
);

    state_t             r_state;
    state_t             w_state_next;
    logic               w_accept;
    logic               w_capture;
    logic [FLAGS_W-1:0] w_flags;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and handshake outputs
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // ALU inputs settle for this whole cycle; capture at its end
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                // A new command may ride the same edge that consumes the result
                in_ready  = out_ready;
                if (out_ready) begin
                    w_state_next = in_valid ? ST_EXEC : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign w_accept  = in_valid && in_ready;
    assign w_capture = (r_state == ST_EXEC);

    always_comb begin
        w_flags          = '0;
        w_flags[FLG_C]    = alu_c;
        w_flags[FLG_ZERO] = alu_zero;
        w_flags[FLG_OVF]  = alu_overflow;
        w_flags[FLG_LT]   = alu_smaller;
        w_flags[FLG_EQ]   = alu_equal;
    end

    // ------------------------------------------------------------------------
    // Operand registers: change only when a command is accepted.
    // When accepting from HOLD, acc already holds the result being consumed,
    // so chaining works back-to-back.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alu_sel <= '0;
            alu_a   <= '0;
            alu_b   <= '0;
        end else if (w_accept) begin
            alu_sel <= in_sel;
            alu_a   <= in_use_acc ? acc : in_a;
            alu_b   <= in_b;
        end
    end

    // ------------------------------------------------------------------------
    // Result capture at the end of EXEC
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_result <= '0;
            out_flags  <= '0;
            acc        <= '0;
            op_count   <= '0;
        end else if (w_capture) begin
            out_result <= alu_result;
            out_flags  <= w_flags;
            acc        <= alu_result;
            op_count   <= op_count + 1'b1;
        end
    end

endmodule : alu_issue_stage
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_stage
// Description : Self-checking bench for alu_issue_stage. A behavioural ALU is
//               attached to the stage (or a fixed-value stub when stub_en=1);
//               a transaction-level model tracks accumulator, counter and
//               expected results per issued command.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_stage;

    localparam int WIDTH = 4;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_sel;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_use_acc;
    logic [2:0]       alu_sel;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic [WIDTH-1:0] alu_result;
    logic             alu_c, alu_zero, alu_overflow, alu_smaller, alu_equal;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [4:0]       out_flags;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] op_count;

    logic             stub_en;

    int total = 0;
    int bad   = 0;

    // transaction-level model state
    logic [3:0] m_acc;
    int         m_cnt;

    always #5 clk = ~clk;

    alu_issue_stage #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_sel       (in_sel),
        .in_a         (in_a),
        .in_b         (in_b),
        .in_use_acc   (in_use_acc),
        .alu_sel      (alu_sel),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_result   (alu_result),
        .alu_c        (alu_c),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .alu_smaller  (alu_smaller),
        .alu_equal    (alu_equal),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_result   (out_result),
        .out_flags    (out_flags),
        .acc          (acc),
        .op_count     (op_count)
    );

    // Behavioural 4-bit ALU: returns {equal, smaller, overflow, zero, c, result[3:0]}
    function automatic logic [8:0] alu_fn(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b);
        logic [4:0] wide;
        logic [3:0] r;
        logic       c, ovf;
        c = 1'b0; ovf = 1'b0; r = 4'd0;
        case (s)
            3'd0: begin wide = {1'b0, a} + {1'b0, b}; r = wide[3:0]; c = wide[4];
                        ovf = (a[3] == b[3]) && (r[3] != a[3]); end
            3'd1: begin wide = {1'b0, a} - {1'b0, b}; r = wide[3:0]; c = wide[4];
                        ovf = (a[3] != b[3]) && (r[3] != a[3]); end
            3'd2: r = ~a;
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: r = (a < b) ? 4'd1 : 4'd0;
            default: r = (a == b) ? 4'd1 : 4'd0;
        endcase
        return {(a == b), (a < b), ovf, (r == 4'd0), c, r};
    endfunction

    logic [8:0] alu_out;
    always_comb begin
        alu_out = stub_en ? {5'b10110, 4'hA} : alu_fn(alu_sel, alu_a, alu_b);
        alu_result   = alu_out[3:0];
        alu_c        = alu_out[4];
        alu_zero     = alu_out[5];
        alu_overflow = alu_out[6];
        alu_smaller  = alu_out[7];
        alu_equal    = alu_out[8];
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1 time unit after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #12;
        rst = 1'b0;
        m_acc = 4'd0;
        m_cnt = 0;
        tick();
    endtask

    // Issue one command from IDLE, check both pipeline phases, then consume.
    task automatic issue(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b,
                         input logic ua, input int stall);
        logic [3:0] opa;
        logic [8:0] exp;
        opa = ua ? m_acc : a;
        exp = stub_en ? {5'b10110, 4'hA} : alu_fn(s, opa, b);
        check_val("idle_ready", in_ready, 1'b1);
        in_valid = 1'b1; in_sel = s; in_a = a; in_b = b; in_use_acc = ua;
        tick();
        in_valid = 1'b0;
        check_val("exec_alu_ops", {alu_sel, alu_a, alu_b}, {s, opa, b});
        check_val("exec_hs", {in_ready, out_valid}, 2'b00);
        tick();
        m_acc = exp[3:0];
        m_cnt = (m_cnt + 1) % 256;
        check_val("hold_valid", out_valid, 1'b1);
        check_val("hold_result", {out_flags, out_result}, exp);
        check_val("hold_acc_cnt", {acc, op_count}, {m_acc, m_cnt[7:0]});
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1; in_a = ~a; in_b = ~b; in_sel = ~s;  // must be ignored
            #1;
            check_val("stall_ready", in_ready, 1'b0);
            tick();
            check_val("stall_stable", {out_valid, out_flags, out_result, alu_a, op_count},
                      {1'b1, exp, opa, m_cnt[7:0]});
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_val("consumed", {out_valid, in_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] e;
        logic [2:0] rs;
        logic [3:0] ra, rb;
        logic [3:0] opa;
        in_valid = 0; in_sel = 0; in_a = 0; in_b = 0; in_use_acc = 0;
        out_ready = 0; stub_en = 0; rst = 0;

        // ---- reset values
        rst = 1'b1;
        #7;
        check_val("reset_regs", {alu_sel, alu_a, alu_b, out_result, out_flags, acc, op_count, out_valid},
                  '0);
        do_reset();
        check_val("reset_ready", in_ready, 1'b1);

        // ---- add 7+1: explicit expected values
        issue(3'd0, 4'd7, 4'd1, 1'b0, 0);
        check_val("add71_acc", acc, 4'd8);

        // ---- accumulator chain: 3+4, then acc+1
        issue(3'd0, 4'd3, 4'd4, 1'b0, 0);
        issue(3'd0, 4'd0, 4'd1, 1'b1, 0);
        check_val("chain_result", out_result, 4'd8);

        // ---- backpressure then same-edge accept from HOLD
        issue(3'd5, 4'hC, 4'h5, 1'b0, 0);
        in_valid = 1'b1; in_sel = 3'd0; in_a = 4'd2; in_b = 4'd2; in_use_acc = 1'b0;
        tick();  // accepted from IDLE, now EXEC
        in_valid = 1'b0;
        tick();  // HOLD
        m_acc = 4'd4; m_cnt = (m_cnt + 1) % 256;
        check_val("bp_first", {out_valid, out_result}, {1'b1, 4'd4});
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_sel = 3'd3; in_a = 4'hF; in_b = 4'h1;
            #1;
            check_val("bp_ready", in_ready, 1'b0);
            tick();
            check_val("bp_stable", {out_valid, out_result, alu_a, alu_b, op_count},
                      {1'b1, 4'd4, 4'd2, 4'd2, m_cnt[7:0]});
        end
        in_valid = 1'b1; in_sel = 3'd1; in_b = 4'd5; in_use_acc = 1'b1;
        out_ready = 1'b1;
        #1;
        check_val("bp_ready_hold", in_ready, 1'b1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0; in_use_acc = 1'b0;
        check_val("bp_exec", {out_valid, in_ready, alu_sel, alu_a, alu_b},
                  {1'b0, 1'b0, 3'd1, 4'd4, 4'd5});
        tick();
        e = alu_fn(3'd1, 4'd4, 4'd5);
        m_acc = e[3:0]; m_cnt = (m_cnt + 1) % 256;
        check_val("bp_second", {out_valid, out_flags, out_result}, {1'b1, e});
        out_ready = 1'b1; tick(); out_ready = 1'b0;

        // ---- stub ALU: flags passed through verbatim
        stub_en = 1'b1;
        issue(3'd3, 4'd1, 4'd2, 1'b0, 1);
        stub_en = 1'b0;
        check_val("stub_acc", acc, 4'hA);

        // ---- reset during EXEC
        in_valid = 1'b1; in_sel = 3'd0; in_a = 4'd5; in_b = 4'd6;
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #3;
        rst = 1'b0;
        m_acc = 4'd0; m_cnt = 0;
        #1;
        check_val("rst_exec", {out_valid, in_ready, op_count, acc}, {1'b1 ^ 1'b1, 1'b1, 8'd0, 4'd0});
        tick(); tick();
        check_val("rst_exec_quiet", {out_valid, op_count}, {1'b0, 8'd0});

        // ---- randomized commands with random stalls
        for (int n = 0; n < 40; n++) begin
            issue(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom),
                  1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
        end

        // ---- 256 back-to-back ops, out_ready tied high
        do_reset();
        out_ready = 1'b1;
        in_use_acc = 1'b0;
        for (int n = 0; n < 256; n++) begin
            rs = 3'($urandom_range(0, 7)); ra = 4'($urandom); rb = 4'($urandom);
            opa = ra;
            in_valid = 1'b1; in_sel = rs; in_a = ra; in_b = rb;
            tick();  // accept -> EXEC
            check_val("b2b_exec", out_valid, 1'b0);
            tick();  // capture -> HOLD
            e = alu_fn(rs, opa, rb);
            m_acc = e[3:0]; m_cnt = (m_cnt + 1) % 256;
            check_val("b2b_hold", {out_valid, out_flags, out_result, acc, op_count},
                      {1'b1, e, m_acc, m_cnt[7:0]});
        end
        in_valid = 1'b0;
        tick();
        check_val("b2b_wrap", {op_count, out_valid}, {8'd0, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_issue_stage
`default_nettype wire

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Sequential front-end that sits directly upstream of the 4-bit combinational ALU.
- Accepts one command (sel, a, b) per valid/ready handshake and registers the operands onto the ALU inputs.
- One cycle later it captures the ALU result and flags into output registers, holding them until consumed.
- Keeps a result accumulator for chained operations and a wrapping count of completed operations.

Parameters:
- WIDTH, 4, operand/result width; must match the ALU datapath (4).
- CNT_W, 8, width of completed-operation counter.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  command present
- in_ready  output  1  stage can accept a command this cycle
- in_sel  input  3  ALU op: 0 add, 1 sub, 2 not a, 3 and, 4 or, 5 xor, 6 less-than, 7 equal
- in_a  input  WIDTH  operand a
- in_b  input  WIDTH  operand b
- in_use_acc  input  1  1 = use accumulator instead of in_a as operand a
- alu_sel  output  3  registered op to ALU
- alu_a  output  WIDTH  registered operand a to ALU
- alu_b  output  WIDTH  registered operand b to ALU
- alu_result  input  WIDTH  ALU result
- alu_c, alu_zero, alu_overflow, alu_smaller, alu_equal  input  1 each  ALU flags
- out_valid  output  1  captured result available
- out_ready  input  1  consumer accepts result
- out_result  output  WIDTH  captured result
- out_flags  output  5  {equal, smaller, overflow, zero, c} captured unchanged from ALU
- acc  output  WIDTH  accumulator (last captured result)
- op_count  output  CNT_W  completed operations, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, rst=1):
  - state IDLE; alu_sel/alu_a/alu_b, out_result, out_flags, acc and op_count all 0; out_valid 0.
  - in_ready is 1 once rst deasserts.
  - Asserting rst mid-operation aborts the command silently; no partial output is produced.
- States:
  - IDLE: in_ready=1, out_valid=0. On in_valid: latch alu_sel=in_sel, alu_a=(in_use_acc ? acc : in_a), alu_b=in_b; go to EXEC.
  - EXEC: in_ready=0. ALU inputs are stable for a full cycle. At the clock edge:
    - out_result<=alu_result, out_flags<=flags, acc<=alu_result, op_count<=op_count+1, out_valid<=1; go to HOLD.
  - HOLD: out_valid=1; outputs are stable while out_ready=0. in_ready = out_ready.
    - out_ready=1 and in_valid=0: out_valid<=0; go to IDLE.
    - out_ready=1 and in_valid=1: the result is consumed and the new command is latched in the same edge (operand a from acc, which already holds the previous result); out_valid<=0; go to EXEC.
- Latency: accept edge to out_valid = 2 clock edges. Peak throughput is 1 op per 2 cycles.
- alu_* outputs hold their last values outside EXEC; they change only on command accept.
- Flags are passed through verbatim; the stage does not interpret or correct them.
- op_count wraps 2^CNT_W-1 -> 0 with no flag.
- acc updates for every op, including logic and compare ops.
- in_* are ignored whenever in_ready=0.

Decomposition:
- Shared package alu_pkg:
  - op encoding constants (OP_ADD=0 … OP_EQ=7)
  - flag bit indices (FLG_C=0, FLG_ZERO=1, FLG_OVF=2, FLG_LT=3, FLG_EQ=4)
  - state encoding (IDLE, EXEC, HOLD)
- Single module, no sub-module. The ALU is instantiated alongside it by the parent, not inside.

Test Plan:
- Reset then add a=7, b=1 with the real ALU attached -> 2 edges later: out_valid=1, out_result=8, out_flags c=0 zero=0 overflow=1; acc=8; op_count=1.
- Accumulator chain: add 3+4 (consume), then in_use_acc=1, sel=0, b=1 -> alu_a=7, out_result=8.
- Backpressure: hold out_ready=0 for 3 cycles after out_valid -> out_result/out_flags stable, in_ready=0, a concurrent in_valid is ignored. Then out_ready=1 with in_valid=1 -> accepted same edge, state EXEC, out_valid=0 next cycle.
- Flag passthrough with stub ALU driving flags=5'b10110, result=4'hA -> out_flags=5'b10110, out_result=4'hA.
- Reset asserted during EXEC -> out_valid stays 0, op_count=0, acc=0, in_ready=1 after release; no result appears.
- 256 back-to-back ops with out_ready tied 1 -> op_count returns to 0; one op completed every 2 cycles.
